encoder_lane_loader: RTL and testbench
======================================

# encoder_lane_loader

Upstream feeder for the encoder control unit and its datapath. It accepts a message block as a stream of 64-bit lanes over a valid/ready handshake and writes them into the encoder's 25-lane state memory in lane order. A short block is zero-padded to 25 lanes. It then issues a single-cycle `enc_start`, tracks the encoder's `Ready` handshake until the block is finished, and re-opens the input for the next block.

## Interface
- `LANE_W`, 64, lane width in bits
- `NUM_LANES`, 25, lanes per block (5x5 grid)
- `ADDR_W`, 5, lane address width, ceil(log2(NUM_LANES))

Ports (clock and reset: reset reset, asynchronous, active-high; clock clk):
- `clk`  in  1  clock
- `reset`  in  1  asynchronous active-high reset
- `in_valid`  in  1  input lane valid
- `in_data`  in  LANE_W  input lane
- `in_last`  in  1  final lane of block
- `in_ready`  out  1  loader accepts lane; high only in LOAD
- `wr_en`  out  1  state-memory write strobe (registered)
- `wr_addr`  out  ADDR_W  lane address, 5*y+x (registered)
- `wr_data`  out  LANE_W  lane data; zero when padding (registered)
- `enc_start`  out  1  start pulse to encoder
- `enc_ready`  in  1  encoder `Ready`; high only while encoder idle
- `busy`  out  1  high in every state except LOAD
- `blk_done`  out  1  one-cycle pulse, block fully encoded

## Operation
- States: LOAD, PAD, FLUSH, KICK, WAIT_ACK, WAIT_DONE. Reset state LOAD.
- Lane index counter: x in 0..4, y in 0..4. x increments per written lane; x wraps 4->0 with y+1; addr = 5*y+x. The counter clears on entry to LOAD.
- LOAD: a lane is accepted on `in_valid & in_ready`. Next cycle `wr_en`=1, `wr_addr`=current index, `wr_data`=`in_data`.
  - Accepted lane at index 24 -> FLUSH. `in_last` is ignored there.
  - Accepted lane with `in_last`=1 at index <24 -> PAD.
  - Otherwise the loader stays in LOAD.
- PAD: writes zero lanes, one per cycle, at the remaining indices up to and including 24. After index 24 is written it goes to FLUSH.
- FLUSH: one cycle so the final registered write commits -> KICK.
- KICK: `enc_start` = `enc_ready` (combinational). If `enc_ready`, go to WAIT_ACK; otherwise hold.
- WAIT_ACK: when `enc_ready`=0, go to WAIT_DONE. This is the encoder leaving Idle.
- WAIT_DONE: when `enc_ready`=1, go to LOAD and pulse `blk_done` (registered) for one cycle on entry.
- Reset, asynchronous and possibly mid-block, forces all registers to zero and the state to LOAD.

## Timing
- Reset values: `in_ready`=1, `busy`=0, and all other outputs 0.
- Write latency: a lane accepted at the edge ending cycle t has `wr_en` high during cycle t+1.
- Full block, no stalls: lanes accepted in cycles 0..24 and writes in 1..25.
  - FLUSH is at cycle 25.
  - KICK is at cycle 26, and `enc_start` is high in cycle 26 if `enc_ready`=1.
- Short block, `in_last` on lane k<24:
  - PAD writes indices k+1..24 in consecutive cycles, starting the cycle after lane k's write.
- `in_ready` drops in the cycle after the accepting edge of the terminating lane.
- There is no combinational path from `in_valid` to `in_ready`.
- `enc_start` is never high for more than one cycle per block and is never high outside KICK.
- `blk_done` goes high in the cycle after the loader samples `enc_ready` rising in WAIT_DONE. `in_ready` is high in that same cycle.
- `in_valid` may toggle freely in LOAD. Gaps stall the counter.

## Structure
- Shared package `encoder_pkg`: `LANE_W`, `NUM_LANES`, `GRID`=5, `ADDR_W`, and the loader state enum.
- Sub-module `lane_index_counter`: x/y counters with clear, increment, wrap, `addr` output, and `at_last` flag (index 24).
- Top module: FSM, registered write port, handshake logic.

## Test plan
- 25 lanes 0x1..0x19 back-to-back, `enc_ready` held 1 -> writes to addresses 0..24 with matching data in cycles 1..25, `enc_start` pulse in cycle 26.
- `in_last` on lane 3 -> addresses 0..3 carry data, addresses 4..24 are written 0x0 in consecutive cycles, then FLUSH and `enc_start`.
- `enc_ready`=0 during KICK for 10 cycles, then 1 -> `enc_start` asserts only in the first cycle with `enc_ready`=1, exactly once.
- Encoder model holds `enc_ready` low for 300 cycles -> `busy`=1 and `in_ready`=0 throughout; `blk_done` pulses once, one cycle after `enc_ready` returns.
- Random `in_valid` gaps over 3 blocks -> write sequence is identical to the stall-free case, with no duplicate or skipped addresses.
- Reset asserted at lane 12 -> all outputs are at reset values immediately; the next block starts at address 0.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared constants, state encoding and lane-address helper for the encoder lane loader.
package encoder_pkg;

  localparam int LANE_W    = 64;
  localparam int NUM_LANES = 25;
  localparam int GRID      = 5;
  localparam int ADDR_W    = 5;
  localparam int IDX_W     = 3;

  typedef enum logic [2:0] {
    ST_LOAD      = 3'd0,
    ST_PAD       = 3'd1,
    ST_FLUSH     = 3'd2,
    ST_KICK      = 3'd3,
    ST_WAIT_ACK  = 3'd4,
    ST_WAIT_DONE = 3'd5
  } loader_state_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [LANE_W-1:0] data;
  } lane_wr_t;

  // Row-major lane address in the 5x5 grid: 5*y + x.
  function automatic logic [ADDR_W-1:0] lane_addr(input logic [IDX_W-1:0] x,
                                                  input logic [IDX_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(GRID) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/encoder_lane_loader_if.sv
// Lane stream in, state-memory write port and encoder handshake out, bundled as one port.
interface encoder_lane_loader_if;
  import encoder_pkg::*;

  logic              in_valid;
  logic [LANE_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [LANE_W-1:0] wr_data;
  logic              enc_start;
  logic              enc_ready;
  logic              busy;
  logic              blk_done;

  modport slave (
    input  in_valid, in_data, in_last, enc_ready,
    output in_ready, wr_en, wr_addr, wr_data, enc_start, busy, blk_done
  );

  modport master (
    output in_valid, in_data, in_last, enc_ready,
    input  in_ready, wr_en, wr_addr, wr_data, enc_start, busy, blk_done
  );

endinterface

// File: rtl/lane_index_counter.sv
// x/y lane index over the 5x5 grid; addr/at_last follow the registered index with zero latency.
// No backpressure: advances only when inc is asserted, clr has priority over inc.
module lane_index_counter
  import encoder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              at_last
);

  localparam logic [IDX_W-1:0] EDGE = IDX_W'(GRID - 1);

  logic [IDX_W-1:0] x;
  logic [IDX_W-1:0] y;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (inc) begin
      if (x == EDGE) begin
        x <= '0;
        y <= (y == EDGE) ? '0 : y + IDX_W'(1);
      end else begin
        x <= x + IDX_W'(1);
      end
    end
  end

  assign addr    = lane_addr(x, y);
  assign at_last = (x == EDGE) && (y == EDGE);

endmodule

// File: rtl/encoder_lane_loader.sv
// Loads a 25-lane block (zero-padded if short) into encoder state memory, writes 1 cycle after accept,
// then kicks the encoder; in_ready is high only in LOAD, so the input is held off until blk_done.
module encoder_lane_loader
  import encoder_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  encoder_lane_loader_if.slave  bus
);

  loader_state_t     state;
  loader_state_t     state_nxt;
  lane_wr_t          wr_q;
  lane_wr_t          wr_nxt;
  logic              done_q;
  logic              done_nxt;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              at_last;
  logic [ADDR_W-1:0] idx;
  logic              accept;

  lane_index_counter u_idx (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .addr    (idx),
    .at_last (at_last)
  );

  // in_ready is purely a state decode, so in_valid never reaches it combinationally.
  assign accept = bus.in_valid && (state == ST_LOAD);

  always_comb begin
    state_nxt = state;
    wr_nxt    = '0;
    done_nxt  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      ST_LOAD: begin
        if (accept) begin
          wr_nxt.en   = 1'b1;
          wr_nxt.addr = idx;
          wr_nxt.data = bus.in_data;
          cnt_inc     = 1'b1;
          if (at_last) begin
            state_nxt = ST_FLUSH;
          end else if (bus.in_last) begin
            state_nxt = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        wr_nxt.en   = 1'b1;
        wr_nxt.addr = idx;
        cnt_inc     = 1'b1;
        if (at_last) begin
          state_nxt = ST_FLUSH;
        end
      end
      // One idle cycle lets the lane-24 write land before the encoder is started.
      ST_FLUSH: state_nxt = ST_KICK;
      ST_KICK: begin
        if (bus.enc_ready) begin
          state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (!bus.enc_ready) begin
          state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.enc_ready) begin
          state_nxt = ST_LOAD;
          done_nxt  = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_LOAD;
      wr_q   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      wr_q   <= wr_nxt;
      done_q <= done_nxt;
    end
  end

  assign bus.in_ready  = (state == ST_LOAD);
  assign bus.busy      = (state != ST_LOAD);
  assign bus.enc_start = (state == ST_KICK) && bus.enc_ready;
  assign bus.wr_en     = wr_q.en;
  assign bus.wr_addr   = wr_q.addr;
  assign bus.wr_data   = wr_q.data;
  assign bus.blk_done  = done_q;

  a_start_single: assert property (@(posedge clk) disable iff (reset)
    bus.enc_start |=> !bus.enc_start);

  a_addr_range: assert property (@(posedge clk) disable iff (reset)
    wr_q.en |-> (wr_q.addr < ADDR_W'(NUM_LANES)));

endmodule

// File: tb/tb_encoder_lane_loader.sv
// Block-level bench: table of block scenarios driven through a cycle-stepped encoder model.
module tb_encoder_lane_loader;
  import encoder_pkg::*;

  logic clk = 1'b0;
  logic reset;

  encoder_lane_loader_if bus ();

  encoder_lane_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // n lanes (in_last on lane n-1), KICK stall, encoder busy length, in_valid gap %, random data,
  // expected enc_start / blk_done cycles relative to the block's first cycle (-1: gapped, derived).
  typedef struct {
    int n;
    int stall;
    int busy_len;
    int gap_pct;
    bit rnd_data;
    int exp_start;
    int exp_done;
  } vec_t;

  vec_t vecs[10];

  int               wa[$];
  logic [LANE_W-1:0] wd[$];
  int               wc[$];

  task automatic run_block(input vec_t v, input int tag);
    logic [LANE_W-1:0] lanes[NUM_LANES];
    logic [LANE_W-1:0] expd;
    int lane_i  = 0;
    int c       = 0;
    int start_c = -1;
    int done_c  = -1;
    int kick_c  = -1;
    int nstart  = 0;
    int viol    = 0;
    int bad     = 0;
    int tbad    = 0;
    for (int i = 0; i < NUM_LANES; i++)
      lanes[i] = v.rnd_data ? {$urandom, $urandom} : LANE_W'(i + 1);
    wa.delete(); wd.delete(); wc.delete();

    while (done_c < 0 && c < 2000) begin
      if (lane_i < v.n) begin
        bus.in_valid = ($urandom_range(0, 99) >= v.gap_pct);
        bus.in_data  = lanes[lane_i];
        bus.in_last  = (lane_i == v.n - 1);
      end else if (start_c < 0 || c <= start_c + v.busy_len + 1) begin
        // Junk offered while the loader must be closed; any acceptance shows up as an extra write.
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = {$urandom, $urandom};
        bus.in_last  = 1'($urandom_range(0, 1));
      end else begin
        bus.in_valid = 1'b0;
      end
      if (start_c < 0) bus.enc_ready = (v.stall == 0) || (kick_c >= 0 && c >= kick_c + v.stall);
      else             bus.enc_ready = (c > start_c + v.busy_len);

      @(negedge clk);
      if (bus.in_ready === bus.busy) viol++;
      if (bus.enc_start && !bus.enc_ready) viol++;
      if (lane_i >= v.n && bus.in_ready && !bus.blk_done) viol++;
      if (bus.blk_done && !bus.in_ready) viol++;
      if (bus.wr_en) begin
        wa.push_back(int'(bus.wr_addr));
        wd.push_back(bus.wr_data);
        wc.push_back(c);
        if (bus.wr_addr == ADDR_W'(NUM_LANES - 1)) kick_c = c + 1;
      end
      if (bus.enc_start) begin
        nstart++;
        if (start_c < 0) start_c = c;
      end
      if (bus.blk_done) done_c = c;
      if (lane_i < v.n && bus.in_valid && bus.in_ready) lane_i++;
      @(posedge clk); #1;
      c++;
    end

    check($sformatf("blk%0d completes", tag), longint'(done_c >= 0), 1);
    if (wa.size() != NUM_LANES) bad++;
    for (int i = 0; i < wa.size() && i < NUM_LANES; i++) begin
      expd = (i < v.n) ? lanes[i] : '0;
      if (wa[i] != i || wd[i] !== expd) bad++;
      if (v.gap_pct == 0 && wc[i] != i + 1) tbad++;
      if (i > 0 && wc[i] <= wc[i-1]) tbad++;
      if (i >= v.n && i > 0 && wc[i] != wc[i-1] + 1) tbad++;
    end
    check($sformatf("blk%0d write seq errors", tag), bad, 0);
    check($sformatf("blk%0d write timing errors", tag), tbad, 0);
    check($sformatf("blk%0d enc_start count", tag), nstart, 1);
    check($sformatf("blk%0d handshake violations", tag), viol, 0);
    if (v.exp_start >= 0) begin
      check($sformatf("blk%0d enc_start cycle", tag), start_c, v.exp_start);
      check($sformatf("blk%0d blk_done cycle", tag), done_c, v.exp_done);
    end else begin
      check($sformatf("blk%0d blk_done after start", tag), done_c - start_c, v.busy_len + 2);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"},  bus.in_ready, 1);
    check({tag, " busy"},      bus.busy, 0);
    check({tag, " wr_en"},     bus.wr_en, 0);
    check({tag, " wr_addr"},   longint'(bus.wr_addr), 0);
    check({tag, " wr_data"},   longint'(bus.wr_data), 0);
    check({tag, " enc_start"}, bus.enc_start, 0);
    check({tag, " blk_done"},  bus.blk_done, 0);
  endtask

  initial begin
    vecs[0] = '{25,  0,   3,  0, 1'b0, 26,  31};
    vecs[1] = '{ 4,  0,   2,  0, 1'b1, 26,  30};
    vecs[2] = '{25, 10,   4,  0, 1'b1, 36,  42};
    vecs[3] = '{25,  0, 300,  0, 1'b1, 26, 328};
    vecs[4] = '{ 1,  0,   1,  0, 1'b1, 26,  29};
    vecs[5] = '{24,  2,   5,  0, 1'b1, 28,  35};
    vecs[6] = '{25,  0,   3, 40, 1'b1, -1,  -1};
    vecs[7] = '{13,  3,   2, 40, 1'b1, -1,  -1};
    vecs[8] = '{25,  0,   6, 60, 1'b1, -1,  -1};
    vecs[9] = '{25,  0,   2,  0, 1'b1, 26,  30};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.enc_ready = 1'b1;
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 9; k++) run_block(vecs[k], k);

    // Reset in the middle of a block: 13 lanes in, lane 12 being written.
    bus.enc_ready = 1'b1;
    bus.in_last   = 1'b0;
    for (int i = 0; i < 13; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 64'hA0 + 64'(i);
      @(posedge clk); #1;
    end
    check("mid wr_en", bus.wr_en, 1);
    check("mid wr_addr", longint'(bus.wr_addr), 12);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("async");
    @(posedge clk); #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    run_block(vecs[9], 9);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
